// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter and its slot picker.
package cdb_arbiter_pkg;

  localparam int CDB_COUNT   = 2;
  localparam int CDB_REQ_MAX = 2;

  typedef logic [1:0] cdb_req_t;

  // A request of 3 slots is treated as the maximum the bus pair can supply.
  function automatic cdb_req_t cdb_clamp(input cdb_req_t r);
    return (r > cdb_req_t'(CDB_REQ_MAX)) ? cdb_req_t'(CDB_REQ_MAX) : r;
  endfunction

endpackage

// File: rtl/cdb_slot_picker.sv
// Combinational slot allocator: walks requesters from start_i, handing out up to free_i slots
// and reporting which requester took the first and second slot of this pass.
module cdb_slot_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 5,
  localparam int IDX_W     = $clog2(REQUESTERS)
) (
  input  cdb_req_t [REQUESTERS-1:0] req_i,
  input  logic [IDX_W-1:0]          start_i,
  input  logic [1:0]                free_i,
  output cdb_req_t [REQUESTERS-1:0] slots_o,
  output logic [1:0]                used_o,
  output logic [IDX_W-1:0]          own0_o,
  output logic [IDX_W-1:0]          own1_o,
  output logic [IDX_W-1:0]          last_o,
  output logic                      last_partial_o,
  output logic                      any_o
);

  localparam logic [IDX_W:0] REQ_N = (IDX_W+1)'(REQUESTERS);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] idx;
  cdb_req_t         want;
  cdb_req_t         take;
  logic [1:0]       free;

  always_comb begin
    slots_o        = '0;
    used_o         = '0;
    own0_o         = '0;
    own1_o         = '0;
    last_o         = '0;
    last_partial_o = 1'b0;
    any_o          = 1'b0;
    free           = free_i;
    pos            = '0;
    idx            = '0;
    want           = '0;
    take           = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      pos = {1'b0, start_i} + (IDX_W+1)'(k);
      if (pos >= REQ_N) pos = pos - REQ_N;
      idx  = pos[IDX_W-1:0];
      want = cdb_clamp(req_i[idx]);
      take = (want < free) ? want : free;
      if (take != '0) begin
        slots_o[idx] = take;
        // Slots are numbered in allocation order; a double grant fills both at once.
        if (used_o == 2'd0) begin
          own0_o = idx;
          if (take == 2'd2) own1_o = idx;
        end else begin
          own1_o = idx;
        end
        last_o         = idx;
        last_partial_o = (take < want);
        any_o          = 1'b1;
        used_o         = used_o + take;
        free           = free - take;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Rotating-priority arbiter granting up to two CDB slots per cycle; grants are combinational.
// Optional starvation promotion is built when CDB_ARB_AGE_EN is defined.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 5,
  parameter int BUSES      = 2,
  parameter int AGE_LIMIT  = 7,
  localparam int IDX_W     = $clog2(REQUESTERS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [REQUESTERS-1:0][1:0] req_cnt,
  output logic [REQUESTERS-1:0]      gnt_bus0,
  output logic [REQUESTERS-1:0]      gnt_bus1,
  output logic [BUSES-1:0]           bus_valid,
  output logic [IDX_W-1:0]           rr_ptr
);

  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  cdb_req_t [REQUESTERS-1:0] norm_req, norm_slots, aged_slots;
  logic [1:0]                norm_free, norm_used, aged_used, total_used;
  logic [IDX_W-1:0]          norm_own0, norm_own1, norm_last;
  logic [IDX_W-1:0]          aged_own0, aged_own1;
  logic [IDX_W-1:0]          own0, own1;
  logic                      norm_partial, norm_any;

`ifdef CDB_ARB_AGE_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [REQUESTERS-1:0][AGE_W-1:0] age_q, age_d;
  cdb_req_t [REQUESTERS-1:0]        aged_req;
  logic [IDX_W-1:0]                 aged_unused_last;
  logic                             aged_unused_partial, aged_unused_any;

  always_comb begin
    aged_req = '0;
    norm_req = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (age_q[i] == AGE_W'(AGE_LIMIT)) aged_req[i] = req_cnt[i];
      // Anyone served by the aged pass is skipped by the normal scan.
      if (aged_slots[i] == '0) norm_req[i] = req_cnt[i];
    end
  end

  cdb_slot_picker #(.REQUESTERS(REQUESTERS)) u_aged_pick (
    .req_i          (aged_req),
    .start_i        ('0),
    .free_i         (2'(CDB_COUNT)),
    .slots_o        (aged_slots),
    .used_o         (aged_used),
    .own0_o         (aged_own0),
    .own1_o         (aged_own1),
    .last_o         (aged_unused_last),
    .last_partial_o (aged_unused_partial),
    .any_o          (aged_unused_any)
  );

  assign norm_free = 2'(CDB_COUNT) - aged_used;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!flush && (aged_slots[i] != '0 || norm_slots[i] != '0)) begin
        age_d[i] = '0;
      end else if (cdb_clamp(req_cnt[i]) != '0 && age_q[i] != AGE_W'(AGE_LIMIT)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) age_q <= '0;
    else        age_q <= age_d;
  end
`else
  logic unused_age_cfg;

  assign unused_age_cfg = (AGE_LIMIT != 0);
  assign aged_slots     = '0;
  assign aged_used      = '0;
  assign aged_own0      = '0;
  assign aged_own1      = '0;
  assign norm_req       = req_cnt;
  assign norm_free      = 2'(CDB_COUNT);
`endif

  cdb_slot_picker #(.REQUESTERS(REQUESTERS)) u_norm_pick (
    .req_i          (norm_req),
    .start_i        (rr_ptr_q),
    .free_i         (norm_free),
    .slots_o        (norm_slots),
    .used_o         (norm_used),
    .own0_o         (norm_own0),
    .own1_o         (norm_own1),
    .last_o         (norm_last),
    .last_partial_o (norm_partial),
    .any_o          (norm_any)
  );

  // Aged slots precede normal-scan slots when mapping onto CDB0 then CDB1.
  always_comb begin
    total_used = aged_used + norm_used;
    own0       = (aged_used != 2'd0) ? aged_own0 : norm_own0;
    case (aged_used)
      2'd2:    own1 = aged_own1;
      2'd1:    own1 = norm_own0;
      default: own1 = norm_own1;
    endcase
    gnt_bus0  = '0;
    gnt_bus1  = '0;
    bus_valid = '0;
    if (!flush && total_used != 2'd0) begin
      gnt_bus0[own0] = 1'b1;
      bus_valid[0]   = 1'b1;
    end
    if (!flush && total_used == 2'd2) begin
      gnt_bus1[own1] = 1'b1;
      bus_valid[1]   = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!flush && norm_any) begin
      if (norm_partial)                                rr_ptr_d = norm_last;
      else if (norm_last == IDX_W'(REQUESTERS - 1))    rr_ptr_d = '0;
      else                                             rr_ptr_d = norm_last + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: the driver queues hand-computed grants, a monitor checks them.
module tb_cdb_arbiter;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic [4:0][1:0] req_cnt = '0;
  logic [4:0]      gnt_bus0, gnt_bus1;
  logic [1:0]      bus_valid;
  logic [2:0]      rr_ptr;

  cdb_arbiter #(.REQUESTERS(5), .BUSES(2), .AGE_LIMIT(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .req_cnt   (req_cnt),
    .gnt_bus0  (gnt_bus0),
    .gnt_bus1  (gnt_bus1),
    .bus_valid (bus_valid),
    .rr_ptr    (rr_ptr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] g0;
    logic [4:0] g1;
    logic [1:0] bv;
    logic [2:0] ptr;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
  endtask

  always @(negedge clock) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk(mon_e.name, "gnt_bus0",  int'(gnt_bus0),  int'(mon_e.g0));
      chk(mon_e.name, "gnt_bus1",  int'(gnt_bus1),  int'(mon_e.g1));
      chk(mon_e.name, "bus_valid", int'(bus_valid), int'(mon_e.bv));
      chk(mon_e.name, "rr_ptr",    int'(rr_ptr),    int'(mon_e.ptr));
    end
  end

  task automatic step(input logic rst, input logic fl, input logic [9:0] rq,
                      input logic [4:0] g0, input logic [4:0] g1, input logic [1:0] bv,
                      input logic [2:0] ptr, input string nm);
    @(posedge clock);
    #1;
    reset   = rst;
    flush   = fl;
    req_cnt = rq;
    sb_q.push_back('{g0, g1, bv, ptr, nm});
  endtask

  // Request words are {idx4, idx3, idx2, idx1, idx0}, two bits each.
  initial begin
    step(0, 0, {2'd0,2'd0,2'd0,2'd0,2'd0}, 5'b00000, 5'b00000, 2'b00, 3'd0, "reset_idle");
    step(0, 0, {2'd0,2'd1,2'd0,2'd1,2'd1}, 5'b00001, 5'b00010, 2'b11, 3'd0, "reset_comb");
    step(1, 0, {2'd0,2'd0,2'd0,2'd0,2'd0}, 5'b00000, 5'b00000, 2'b00, 3'd0, "release");
    step(1, 0, {2'd0,2'd1,2'd0,2'd1,2'd1}, 5'b00001, 5'b00010, 2'b11, 3'd0, "three_req");
    step(1, 0, {2'd0,2'd0,2'd0,2'd0,2'd0}, 5'b00000, 5'b00000, 2'b00, 3'd2, "ptr_adv2");
    step(1, 0, {2'd0,2'd0,2'd1,2'd0,2'd0}, 5'b00100, 5'b00000, 2'b01, 3'd2, "single");
    step(1, 0, {2'd2,2'd0,2'd0,2'd0,2'd0}, 5'b10000, 5'b10000, 2'b11, 3'd3, "double_own");
    step(1, 0, {2'd0,2'd0,2'd0,2'd3,2'd1}, 5'b00001, 5'b00010, 2'b11, 3'd0, "wrap_partial");
    step(1, 0, {2'd0,2'd0,2'd0,2'd1,2'd0}, 5'b00010, 5'b00000, 2'b01, 3'd1, "partial_first");
    step(1, 1, {2'd1,2'd1,2'd1,2'd1,2'd1}, 5'b00000, 5'b00000, 2'b00, 3'd2, "flush");
    step(1, 0, {2'd1,2'd1,2'd1,2'd1,2'd1}, 5'b00100, 5'b01000, 2'b11, 3'd2, "after_flush");
    step(1, 0, {2'd2,2'd2,2'd2,2'd2,2'd2}, 5'b10000, 5'b10000, 2'b11, 3'd4, "all_two");
    step(1, 0, {2'd1,2'd1,2'd1,2'd1,2'd1}, 5'b00001, 5'b00010, 2'b11, 3'd0, "all_one");
    step(1, 0, {2'd1,2'd0,2'd0,2'd0,2'd2}, 5'b10000, 5'b00001, 2'b11, 3'd2, "wrap_split");
    step(1, 0, {2'd0,2'd1,2'd0,2'd0,2'd1}, 5'b00001, 5'b01000, 2'b11, 3'd0, "gap_pair");
    step(1, 0, {2'd0,2'd0,2'd1,2'd0,2'd0}, 5'b00100, 5'b00000, 2'b01, 3'd4, "long_scan");
    step(1, 1, {2'd1,2'd1,2'd1,2'd1,2'd1}, 5'b00000, 5'b00000, 2'b00, 3'd3, "burst_flush");
    // Reset drops between edges while rr_ptr is 3; it must read 0 before the next edge.
    @(posedge clock);
    #1;
    flush   = 1'b0;
    req_cnt = {2'd1,2'd1,2'd1,2'd1,2'd1};
    #1;
    reset   = 1'b0;
    sb_q.push_back('{5'b00001, 5'b00010, 2'b11, 3'd0, "async_reset"});
    step(1, 0, {2'd1,2'd1,2'd1,2'd1,2'd1}, 5'b00001, 5'b00010, 2'b11, 3'd0, "post_reset");
    step(1, 0, {2'd0,2'd0,2'd0,2'd0,2'd0}, 5'b00000, 5'b00000, 2'b00, 3'd2, "final_ptr");
    for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(posedge clock);
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", sb_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
